// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one fixed-latency memory port between two requesters
module mem_bus_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MEM_LAT   = 1,
  parameter int MEM_BYTES = 128
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_rw,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic          r0_err,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_rw,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic          r1_err,
  output logic [DW-1:0] r1_rdata,
  output logic          m_en,
  output logic          m_rw,
  output logic [AW-1:0] m_abus,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam logic [AW-1:0] MAX_ADDR = AW'(MEM_BYTES - 4);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic last, any_req, gnt, g_rw, g_err;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [1:0] ack, err;
  logic [DW-1:0] rdata [2];
  assign any_req = r0_req | r1_req;
  assign gnt     = (r0_req & r1_req) ? ~last : r1_req;
  assign g_rw    = gnt ? r1_rw : r0_rw;
  assign g_addr  = gnt ? r1_addr : r0_addr;
  assign g_wdata = gnt ? r1_wdata : r0_wdata;
  assign g_err   = g_addr > MAX_ADDR;
  assign busy    = state != IDLE;
  assign {r1_ack, r0_ack} = ack;
  assign {r1_err, r0_err} = err;
  assign r0_rdata = rdata[0];
  assign r1_rdata = rdata[1];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = g_err ? DONE : ACCESS;
      ACCESS:  if (cnt == '0) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // the m_* registers double as the latched request for the whole access
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      cnt      <= '0;
      m_en     <= 1'b0;
      m_rw     <= 1'b0;
      m_abus   <= '0;
      m_wdata  <= '0;
      ack      <= '0;
      err      <= '0;
      rdata[0] <= '0;
      rdata[1] <= '0;
    end else begin
      state <= state_n;
      ack   <= '0;
      err   <= '0;
      if (state == IDLE && any_req) begin
        owner <= gnt;
        last  <= gnt;
        if (g_err) begin
          ack[gnt] <= 1'b1;
          err[gnt] <= 1'b1;
        end else begin
          m_en    <= 1'b1;
          m_rw    <= g_rw;
          m_abus  <= g_addr;
          m_wdata <= g_rw ? '0 : g_wdata;
          cnt     <= CW'(MEM_LAT - 1);
        end
      end
      if (state == ACCESS) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          m_en       <= 1'b0;
          m_rw       <= 1'b0;
          m_abus     <= '0;
          m_wdata    <= '0;
          ack[owner] <= 1'b1;
          if (m_rw) rdata[owner] <= m_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus a randomized run against a transaction-level arbiter model
module tb_mem_bus_arbiter;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic r0_req = 1'b0, r0_rw = 1'b0, r1_req = 1'b0, r1_rw = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
  logic r0_ack, r0_err, r1_ack, r1_err, m_en, m_rw, busy, owner;
  logic [31:0] r0_rdata, r1_rdata, m_abus, m_wdata, m_rdata;
  logic s_r0_req = 1'b0, s_r0_rw = 1'b1, s_r1_req = 1'b0, s_r1_rw = 1'b1;
  logic [31:0] s_r0_addr = '0, s_r0_wdata = '0, s_r1_addr = '0, s_r1_wdata = '0;
  logic s_r0_ack, s_r0_err, s_r1_ack, s_r1_err, s_m_en, s_m_rw, s_busy, s_owner;
  logic [31:0] s_r0_rdata, s_r1_rdata, s_m_abus, s_m_wdata, s_m_rdata;
  logic [7:0] mem1 [128];
  logic [7:0] ref_mem [128];
  int errors = 0, checks = 0;

  mem_bus_arbiter #(.MEM_LAT(LAT)) u1 (
    .clock(clk), .reset(reset),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .m_en(m_en), .m_rw(m_rw), .m_abus(m_abus), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  mem_bus_arbiter #(.MEM_LAT(3)) u3 (
    .clock(clk), .reset(reset),
    .r0_req(s_r0_req), .r0_rw(s_r0_rw), .r0_addr(s_r0_addr), .r0_wdata(s_r0_wdata),
    .r0_ack(s_r0_ack), .r0_err(s_r0_err), .r0_rdata(s_r0_rdata),
    .r1_req(s_r1_req), .r1_rw(s_r1_rw), .r1_addr(s_r1_addr), .r1_wdata(s_r1_wdata),
    .r1_ack(s_r1_ack), .r1_err(s_r1_err), .r1_rdata(s_r1_rdata),
    .m_en(s_m_en), .m_rw(s_m_rw), .m_abus(s_m_abus), .m_wdata(s_m_wdata), .m_rdata(s_m_rdata),
    .busy(s_busy), .owner(s_owner)
  );

  // big-endian byte memory; the LAT=3 instance only ever reads it
  assign m_rdata = {mem1[m_abus[6:0]], mem1[m_abus[6:0]+7'd1], mem1[m_abus[6:0]+7'd2], mem1[m_abus[6:0]+7'd3]};
  assign s_m_rdata = {mem1[s_m_abus[6:0]], mem1[s_m_abus[6:0]+7'd1], mem1[s_m_abus[6:0]+7'd2], mem1[s_m_abus[6:0]+7'd3]};
  always @(posedge clk) begin
    if (m_en && !m_rw) begin
      mem1[m_abus[6:0]]       <= m_wdata[31:24];
      mem1[m_abus[6:0]+7'd1]  <= m_wdata[23:16];
      mem1[m_abus[6:0]+7'd2]  <= m_wdata[15:8];
      mem1[m_abus[6:0]+7'd3]  <= m_wdata[7:0];
    end
  end

  function automatic logic [31:0] mem_word(input logic [6:0] a);
    return {mem1[a], mem1[a+7'd1], mem1[a+7'd2], mem1[a+7'd3]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [6:0] a);
    return {ref_mem[a], ref_mem[a+7'd1], ref_mem[a+7'd2], ref_mem[a+7'd3]};
  endfunction

  function automatic logic [31:0] rnd_addr();
    int s;
    s = int'($urandom_range(0, 9));
    return s < 6 ? 32'($urandom_range(0, 31)) * 4 : s < 8 ? 32'($urandom_range(0, 124)) :
           s < 9 ? 32'($urandom_range(125, 131)) : ($urandom | 32'h100);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input bit p, output int n, output int en_cnt, output int oth);
    n = 0; en_cnt = 0; oth = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (m_en) en_cnt++;
      if (p ? r0_ack : r1_ack) oth++;
      if (p ? r1_ack : r0_ack) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    checks++; if ({m_en, m_rw, r0_ack, r1_ack, r0_err, r1_err, owner, busy} !== 8'h0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {m_en, m_rw, r0_ack, r1_ack, r0_err, r1_err, owner, busy}); end
    checks++; if ({m_abus, m_wdata} !== 64'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", {m_abus, m_wdata}); end
    checks++; if ({r0_rdata, r1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {r0_rdata, r1_rdata}); end
    checks++; if ({s_m_en, s_m_rw, s_r0_ack, s_r1_ack, s_r0_err, s_r1_err, s_owner, s_busy, s_m_abus, s_m_wdata, s_r0_rdata, s_r1_rdata} !== 136'h0) begin errors++; $display("FAIL reset_lat3: outputs not all zero"); end
    reset = 1'b0;
  endtask

  task automatic test_read_basic;
    int n, en, oth;
    r0_rw = 1'b1; r0_addr = 32'h0; r0_req = 1'b1;
    wait_ack(1'b0, n, en, oth);
    r0_req = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL read_basic latency: got %0d want 2", n); end
    checks++; if (en !== 1) begin errors++; $display("FAIL read_basic m_en cycles: got %0d want 1", en); end
    checks++; if (r0_rdata !== 32'h001F0018) begin errors++; $display("FAIL read_basic rdata: got %h want 001f0018", r0_rdata); end
    checks++; if (r0_err !== 1'b0) begin errors++; $display("FAIL read_basic err: got %b want 0", r0_err); end
    checks++; if (oth !== 0) begin errors++; $display("FAIL read_basic r1_ack: got %0d pulses want 0", oth); end
    idle(1);
  endtask

  task automatic test_write_read;
    int n, en, oth;
    r1_rw = 1'b0; r1_addr = 32'h20; r1_wdata = 32'hDEADBEEF; r1_req = 1'b1;
    @(negedge clk);
    checks++; if ({m_en, m_rw, m_abus, m_wdata} !== {1'b1, 1'b0, 32'h20, 32'hDEADBEEF}) begin errors++; $display("FAIL write_bus: got en=%b rw=%b a=%h d=%h want 1 0 20 deadbeef", m_en, m_rw, m_abus, m_wdata); end
    wait_ack(1'b1, n, en, oth);
    r1_req = 1'b0;
    checks++; if (n !== 1) begin errors++; $display("FAIL write_ack: got %0d want 1", n); end
    idle(1);
    checks++; if ({mem1[32], mem1[33], mem1[34], mem1[35]} !== 32'hDEADBEEF) begin errors++; $display("FAIL write_mem: got %h want deadbeef", {mem1[32], mem1[33], mem1[34], mem1[35]}); end
    r1_rw = 1'b1; r1_req = 1'b1;
    @(negedge clk);
    checks++; if ({m_en, m_rw, m_abus, m_wdata} !== {1'b1, 1'b1, 32'h20, 32'h0}) begin errors++; $display("FAIL read_bus: got en=%b rw=%b a=%h d=%h want 1 1 20 0", m_en, m_rw, m_abus, m_wdata); end
    wait_ack(1'b1, n, en, oth);
    r1_req = 1'b0;
    checks++; if (r1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_back: got %h want deadbeef", r1_rdata); end
    idle(1);
  endtask

  task automatic test_fairness;
    int k;
    k = 0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    r0_rw = 1'b1; r0_addr = 32'h10; r1_rw = 1'b1; r1_addr = 32'h40;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        checks++; if ({r1_ack, r0_ack} !== ((k % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_order #%0d: got %b want %b", k, {r1_ack, r0_ack}, (k % 2) ? 2'b10 : 2'b01); end
        checks++; if (n !== 2 + (LAT + 2) * k) begin errors++; $display("FAIL fair_spacing #%0d: got %0d want %0d", k, n, 2 + (LAT + 2) * k); end
        k++;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    checks++; if (k !== 6) begin errors++; $display("FAIL fair_count: got %0d want 6", k); end
    checks++; if (r1_rdata !== mem_word(7'h40)) begin errors++; $display("FAIL fair_rdata: got %h want %h", r1_rdata, mem_word(7'h40)); end
    idle(2);
  endtask

  task automatic test_range;
    int n, en, oth;
    logic [31:0] prev;
    prev = mem_word(7'h10);
    r0_rw = 1'b1; r0_addr = 32'h7D; r0_req = 1'b1;
    wait_ack(1'b0, n, en, oth);
    r0_req = 1'b0;
    checks++; if (n !== 1 || en !== 0) begin errors++; $display("FAIL range_7d: got lat=%0d en=%0d want 1 0", n, en); end
    checks++; if (r0_err !== 1'b1) begin errors++; $display("FAIL range_7d err: got %b want 1", r0_err); end
    checks++; if (r0_rdata !== prev) begin errors++; $display("FAIL range_7d rdata: got %h want %h", r0_rdata, prev); end
    idle(1);
    r0_rw = 1'b0; r0_addr = 32'hFFFF_FFFC; r0_wdata = 32'h12345678; r0_req = 1'b1;
    wait_ack(1'b0, n, en, oth);
    r0_req = 1'b0;
    checks++; if (n !== 1 || en !== 0 || r0_err !== 1'b1) begin errors++; $display("FAIL range_wr: got lat=%0d en=%0d err=%b want 1 0 1", n, en, r0_err); end
    idle(1);
    r0_rw = 1'b1; r0_addr = 32'h7C; r0_req = 1'b1;
    wait_ack(1'b0, n, en, oth);
    r0_req = 1'b0;
    checks++; if (n !== 2 || en !== 1 || r0_err !== 1'b0) begin errors++; $display("FAIL range_7c: got lat=%0d en=%0d err=%b want 2 1 0", n, en, r0_err); end
    checks++; if (r0_rdata !== mem_word(7'h7C)) begin errors++; $display("FAIL range_7c rdata: got %h want %h", r0_rdata, mem_word(7'h7C)); end
    idle(1);
  endtask

  task automatic test_busy_hold;
    int ack0_at, r1_seen;
    logic [4:0] exp_busy;
    ack0_at = 0; r1_seen = 0; exp_busy = 5'b11011;
    r1_rw = 1'b1; r1_addr = 32'h40; r1_req = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) begin r0_rw = 1'b1; r0_addr = 32'h04; r0_req = 1'b1; end
      if (n <= 5) begin
        checks++; if (busy !== exp_busy[n-1]) begin errors++; $display("FAIL busy_hold busy@%0d: got %b want %b", n, busy, exp_busy[n-1]); end
      end
      if (r1_ack) begin
        r1_req = 1'b0; r1_seen++;
        checks++; if (n !== 2) begin errors++; $display("FAIL busy_hold r1_ack: got %0d want 2", n); end
      end
      if (r0_ack && ack0_at == 0) begin ack0_at = n; r0_req = 1'b0; end
    end
    checks++; if (ack0_at !== 5 || r1_seen !== 1) begin errors++; $display("FAIL busy_hold r0_ack: got at=%0d r1=%0d want 5 1", ack0_at, r1_seen); end
    checks++; if (r0_rdata !== mem_word(7'h04)) begin errors++; $display("FAIL busy_hold rdata: got %h want %h", r0_rdata, mem_word(7'h04)); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    int n0, s0, s1;
    n0 = 0; s0 = 0; s1 = 0;
    s_r0_addr = 32'h08; s_r0_req = 1'b1;
    for (int n = 1; n <= 10 && n0 == 0; n++) begin
      @(negedge clk);
      if (s_r0_ack) begin n0 = n; s_r0_req = 1'b0; end
    end
    checks++; if (n0 !== 4 || s_r0_rdata !== mem_word(7'h08)) begin errors++; $display("FAIL lat3_read: got lat=%0d d=%h want 4 %h", n0, s_r0_rdata, mem_word(7'h08)); end
    idle(1);
    s_r0_addr = 32'h0C; s_r0_req = 1'b1;
    @(negedge clk);
    checks++; if (s_m_en !== 1'b1) begin errors++; $display("FAIL lat3_access m_en: got %b want 1", s_m_en); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({s_m_en, s_busy, s_r0_ack, s_r1_ack, s_m_abus, s_r0_rdata} !== 68'h0) begin errors++; $display("FAIL reset_mid: got en=%b busy=%b ack=%b%b a=%h d=%h want all 0", s_m_en, s_busy, s_r1_ack, s_r0_ack, s_m_abus, s_r0_rdata); end
    reset = 1'b0;
    s_r1_addr = 32'h10; s_r1_req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (s_r0_ack) begin
        s_r0_req = 1'b0; s0++;
        checks++; if (n !== 4 || s_r0_rdata !== mem_word(7'h0C)) begin errors++; $display("FAIL reset_mid r0: got lat=%0d d=%h want 4 %h", n, s_r0_rdata, mem_word(7'h0C)); end
      end
      if (s_r1_ack) begin
        s_r1_req = 1'b0; s1++;
        checks++; if (n !== 9) begin errors++; $display("FAIL reset_mid r1: got %0d want 9", n); end
      end
    end
    checks++; if (s0 !== 1 || s1 !== 1) begin errors++; $display("FAIL reset_mid acks: got r0=%0d r1=%0d want 1 1", s0, s1); end
  endtask

  task automatic test_random;
    int cyc, ready_at, en_from, en_to, bad;
    int ack_at [2];
    bit exp_err [2];
    bit pend_rd [2];
    logic [31:0] exp_rd [2];
    logic [31:0] pend [2];
    logic [31:0] a, wd;
    bit last, p, rw;
    reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
    idle(2);
    for (int i = 0; i < 128; i++) ref_mem[i] = mem1[i];
    reset = 1'b0;
    cyc = 0; ready_at = 1; en_from = -1; en_to = -2; last = 1'b1;
    ack_at = '{-1, -1}; exp_err = '{0, 0}; pend_rd = '{0, 0};
    exp_rd = '{32'h0, 32'h0}; pend = '{32'h0, 32'h0};
    repeat (600) begin
      @(posedge clk);
      cyc++;
      // one transaction at a time; round robin on ties; a free slot opens two cycles after completion
      if (cyc >= ready_at && (r0_req || r1_req)) begin
        p = (r0_req && r1_req) ? !last : r1_req;
        last = p;
        a = p ? r1_addr : r0_addr;
        rw = p ? r1_rw : r0_rw;
        wd = p ? r1_wdata : r0_wdata;
        pend_rd[p] = 1'b0;
        if (a > 32'd124) begin
          ack_at[p] = cyc; exp_err[p] = 1'b1; ready_at = cyc + 2;
        end else begin
          ack_at[p] = cyc + LAT; exp_err[p] = 1'b0;
          en_from = cyc; en_to = cyc + LAT - 1; ready_at = cyc + LAT + 2;
          pend_rd[p] = rw;
          if (rw) pend[p] = ref_word(a[6:0]);
          else for (int b = 0; b < 4; b++) ref_mem[a[6:0] + 7'(b)] = wd[31 - 8*b -: 8];
        end
      end
      for (int q = 0; q < 2; q++) if (ack_at[q] == cyc && pend_rd[q]) exp_rd[q] = pend[q];
      @(negedge clk);
      checks++; if (r0_ack !== (ack_at[0] == cyc) || r0_err !== (ack_at[0] == cyc && exp_err[0])) begin errors++; $display("FAIL rand r0 ack/err @%0d: got %b%b want %b%b", cyc, r0_ack, r0_err, ack_at[0] == cyc, ack_at[0] == cyc && exp_err[0]); end
      checks++; if (r1_ack !== (ack_at[1] == cyc) || r1_err !== (ack_at[1] == cyc && exp_err[1])) begin errors++; $display("FAIL rand r1 ack/err @%0d: got %b%b want %b%b", cyc, r1_ack, r1_err, ack_at[1] == cyc, ack_at[1] == cyc && exp_err[1]); end
      checks++; if (r0_rdata !== exp_rd[0] || r1_rdata !== exp_rd[1]) begin errors++; $display("FAIL rand rdata @%0d: got %h %h want %h %h", cyc, r0_rdata, r1_rdata, exp_rd[0], exp_rd[1]); end
      checks++; if (m_en !== (cyc >= en_from && cyc <= en_to)) begin errors++; $display("FAIL rand m_en @%0d: got %b want %b", cyc, m_en, cyc >= en_from && cyc <= en_to); end
      if (r0_ack || !r0_req) begin
        r0_req = $urandom_range(0, 2) != 0; r0_rw = 1'($urandom_range(0, 1)); r0_addr = rnd_addr(); r0_wdata = $urandom;
      end
      if (r1_ack || !r1_req) begin
        r1_req = $urandom_range(0, 2) != 0; r1_rw = 1'($urandom_range(0, 1)); r1_addr = rnd_addr(); r1_wdata = $urandom;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    idle(8);
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem1[i] !== ref_mem[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand memory image: got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem1[i] <= 8'($urandom);
    mem1[0] <= 8'h00; mem1[1] <= 8'h1F; mem1[2] <= 8'h00; mem1[3] <= 8'h18;
    test_reset;
    test_read_basic;
    test_write_read;
    test_fairness;
    test_range;
    test_busy_hold;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
